// File: rtl/data_mem_burst_master.sv
// Burst initiator for the data memory port.
// Splits core read/write commands into per-cycle memory strobes.
module data_mem_burst_master #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int MAX_BURST = 8,
  parameter int LEN_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_access_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_en,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE
  } state_t;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BURST);
  localparam logic [LEN_W-1:0] ONE_LEN = LEN_W'(1);

  state_t state, state_nx;

  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  count;
  logic [LEN_W-1:0]  len_clamped;
  logic              last;
  logic              slot_free;
  logic              cmd_fire;
  logic              wr_fire;

  always_comb begin
    len_clamped = cmd_len;
    if (cmd_len == '0) begin
      len_clamped = ONE_LEN;
    end else if (cmd_len > MAX_LEN) begin
      len_clamped = MAX_LEN;
    end
  end

  assign last      = (count == ONE_LEN);
  assign slot_free = !rd_valid || rd_ready;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign wr_fire   = wr_valid && wr_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    cmd_ready    = 1'b0;
    wr_ready     = 1'b0;
    mem_write_en = 1'b0;
    mem_read     = 1'b0;
    done         = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_nx = cmd_write ? WRITE : READ;
        end
      end
      WRITE: begin
        wr_ready     = 1'b1;
        mem_write_en = wr_valid;
        if (wr_valid && last) begin
          state_nx = DONE;
        end
      end
      READ: begin
        mem_read = slot_free;
        if (slot_free && last) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (rd_valid && rd_ready) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Reset edge must never commit a handshake or a memory write.
    if (rst) begin
      cmd_ready    = 1'b0;
      wr_ready     = 1'b0;
      mem_write_en = 1'b0;
      mem_read     = 1'b0;
      done         = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (cmd_fire) begin
        cur_addr <= cmd_addr;
        count    <= len_clamped;
      end else if (wr_fire || mem_read) begin
        cur_addr <= cur_addr + ADDR_W'(1);
        count    <= count - ONE_LEN;
      end
      // A load into a freed slot wins over the consume-clear.
      if (mem_read) begin
        rd_data  <= mem_read_data;
        rd_valid <= 1'b1;
      end else if (rd_ready) begin
        rd_valid <= 1'b0;
      end
    end
  end

  assign busy            = (state != IDLE);
  assign mem_access_addr = cur_addr;
  assign mem_write_data  = wr_data;

endmodule

// File: tb/tb_data_mem_burst_master.sv
// Directed bench for data_mem_burst_master.
// Drives at negedge, samples #1 later; memory is an 8-word alias model.
module tb_data_mem_burst_master;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [15:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [15:0] rd_data;
  logic        busy;
  logic        done;
  logic [15:0] mem_access_addr;
  logic [15:0] mem_write_data;
  logic        mem_write_en;
  logic        mem_read;
  logic [15:0] mem_read_data;

  data_mem_burst_master dut (
    .clk             (clk),
    .rst             (rst),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_write       (cmd_write),
    .cmd_addr        (cmd_addr),
    .cmd_len         (cmd_len),
    .wr_valid        (wr_valid),
    .wr_ready        (wr_ready),
    .wr_data         (wr_data),
    .rd_valid        (rd_valid),
    .rd_ready        (rd_ready),
    .rd_data         (rd_data),
    .busy            (busy),
    .done            (done),
    .mem_access_addr (mem_access_addr),
    .mem_write_data  (mem_write_data),
    .mem_write_en    (mem_write_en),
    .mem_read        (mem_read),
    .mem_read_data   (mem_read_data)
  );

  logic [15:0] mem [8];
  logic [15:0] wd [16];
  logic [15:0] wa [$];
  logic [15:0] wdq [$];
  logic [15:0] rq [$];
  int          ndone;
  int          n_chk;
  int          n_err;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign mem_read_data = mem[mem_access_addr[2:0]];

  always @(posedge clk) begin
    if (mem_write_en) begin
      mem[mem_access_addr[2:0]] <= mem_write_data;
      wa.push_back(mem_access_addr);
      wdq.push_back(mem_write_data);
    end
    if (rd_valid && rd_ready) rq.push_back(rd_data);
    if (done) ndone++;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run(input logic w, input logic [15:0] a,
                     input logic [3:0] l, input bit alt, input bit inject,
                     input int rst_after, output int done_cyc,
                     output int nrd_done);
    int          widx;
    bit          fin;
    bit          wfire;
    bit          prev_stall;
    logic [15:0] prev_data;
    wa.delete();
    wdq.delete();
    rq.delete();
    widx       = 0;
    fin        = 0;
    prev_stall = 0;
    prev_data  = '0;
    done_cyc   = -1;
    nrd_done   = -1;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_len   = l;
    #1;
    check("cmd_ready", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
      @(negedge clk);
      wr_valid = w;
      wr_data  = wd[widx];
      rd_ready = alt ? (cyc % 2 == 0) : 1'b1;
      if (inject) begin
        cmd_valid = 1'b1;
        cmd_write = !w;
        cmd_addr  = 16'h0005;
        cmd_len   = 4'd1;
      end
      #1;
      check("strobe_excl", {31'd0, mem_read & mem_write_en}, 0);
      if (!w && cyc == 0) check("rd_lat0", rd_valid, 0);
      if (!w && cyc == 1) check("rd_lat1", rd_valid, 1);
      if (prev_stall) begin
        check("hold_valid", rd_valid, 1);
        check("hold_data", rd_data, prev_data);
      end
      if (rd_valid && !rd_ready) check("stall_noread", mem_read, 0);
      prev_stall = rd_valid && !rd_ready;
      prev_data  = rd_data;
      if (rst_after > 0 && widx == rst_after) begin
        rst = 1'b1;
        #1;
        check("rst_nowrite", mem_write_en, 0);
        check("rst_nowrrdy", wr_ready, 0);
        @(posedge clk);
        @(negedge clk);
        rst      = 1'b0;
        wr_valid = 1'b0;
        #1;
        check("rst_idle", busy, 0);
        check("rst_nodone", done, 0);
        fin = 1;
      end else if (done) begin
        check("done_cmdrdy", cmd_ready, 0);
        done_cyc = cyc;
        nrd_done = rq.size();
        fin      = 1;
        @(posedge clk);
      end else begin
        wfire = wr_valid && wr_ready;
        @(posedge clk);
        if (wfire) widx++;
      end
    end
    if (!fin) check("timeout", 0, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    wr_valid  = 1'b0;
    rd_ready  = 1'b0;
  endtask

  initial begin
    int dc;
    int nr;
    int d0;
    n_chk = 0;
    n_err = 0;
    ndone = 0;
    for (int i = 0; i < 8; i++) mem[i] = 16'h1000 + 16'(i);
    for (int i = 0; i < 16; i++) wd[i] = '0;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    wr_valid  = 1'b0;
    wr_data   = '0;
    rd_ready  = 1'b0;

    // 1: reset
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_cmdrdy", cmd_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("r_cmd_ready", cmd_ready, 1);
    check("r_busy", busy, 0);
    check("r_rd_valid", rd_valid, 0);
    check("r_done", done, 0);
    check("r_wen", mem_write_en, 0);
    check("r_mrd", mem_read, 0);

    // 2: write then read back
    wd[0] = 16'hA1A1;
    wd[1] = 16'hB2B2;
    wd[2] = 16'hC3C3;
    d0 = ndone;
    run(1'b1, 16'h0002, 4'd3, 0, 0, 0, dc, nr);
    check("w3_cnt", wa.size(), 3);
    check("w3_a0", wa[0], 16'h0002);
    check("w3_a1", wa[1], 16'h0003);
    check("w3_a2", wa[2], 16'h0004);
    check("w3_d0", wdq[0], 16'hA1A1);
    check("w3_d1", wdq[1], 16'hB2B2);
    check("w3_d2", wdq[2], 16'hC3C3);
    check("w3_donecyc", dc, 3);
    check("w3_ndone", ndone - d0, 1);
    d0 = ndone;
    run(1'b0, 16'h0002, 4'd3, 0, 0, 0, dc, nr);
    check("r3_cnt", rq.size(), 3);
    check("r3_d0", rq[0], 16'hA1A1);
    check("r3_d1", rq[1], 16'hB2B2);
    check("r3_d2", rq[2], 16'hC3C3);
    check("r3_donecyc", dc, 4);
    check("r3_ndone", ndone - d0, 1);

    // 3: read with alternating rd_ready
    d0 = ndone;
    run(1'b0, 16'h0001, 4'd4, 1, 0, 0, dc, nr);
    check("ra_cnt", rq.size(), 4);
    check("ra_d0", rq[0], 16'h1001);
    check("ra_d1", rq[1], 16'hA1A1);
    check("ra_d2", rq[2], 16'hB2B2);
    check("ra_d3", rq[3], 16'hC3C3);
    check("ra_done_after", nr, 4);
    check("ra_ndone", ndone - d0, 1);

    // 4: address wrap and length clamping
    wd[0] = 16'hD4D4;
    wd[1] = 16'hE5E5;
    run(1'b1, 16'hFFFF, 4'd2, 0, 0, 0, dc, nr);
    check("wrap_cnt", wa.size(), 2);
    check("wrap_a0", wa[0], 16'hFFFF);
    check("wrap_a1", wa[1], 16'h0000);
    check("wrap_m7", mem[7], 16'hD4D4);
    check("wrap_m0", mem[0], 16'hE5E5);
    run(1'b1, 16'h0005, 4'd0, 0, 0, 0, dc, nr);
    check("len0_cnt", wa.size(), 1);
    check("len0_a0", wa[0], 16'h0005);
    check("len0_donecyc", dc, 1);
    for (int i = 0; i < 16; i++) wd[i] = 16'h5000 + 16'(i);
    run(1'b1, 16'h0000, 4'd12, 0, 0, 0, dc, nr);
    check("len12_cnt", wa.size(), 8);
    check("len12_a7", wa[7], 16'h0007);
    check("len12_d7", wdq[7], 16'h5007);
    check("len12_donecyc", dc, 8);

    // 5: reset mid-burst
    for (int i = 0; i < 16; i++) wd[i] = 16'h6000 + 16'(i);
    d0 = ndone;
    run(1'b1, 16'h0000, 4'd5, 0, 0, 2, dc, nr);
    check("rstb_cnt", wa.size(), 2);
    check("rstb_ndone", ndone - d0, 0);
    d0 = ndone;
    run(1'b0, 16'h0000, 4'd3, 0, 0, 0, dc, nr);
    check("rstb_r_cnt", rq.size(), 3);
    check("rstb_r0", rq[0], 16'h6000);
    check("rstb_r1", rq[1], 16'h6001);
    check("rstb_r2", rq[2], 16'h5002);
    check("rstb_r_ndone", ndone - d0, 1);

    // 6: command offered during a burst
    wd[0] = 16'h7000;
    wd[1] = 16'h7001;
    d0 = ndone;
    run(1'b1, 16'h0003, 4'd2, 0, 1, 0, dc, nr);
    check("inj_cnt", wa.size(), 2);
    check("inj_a0", wa[0], 16'h0003);
    check("inj_a1", wa[1], 16'h0004);
    check("inj_d1", wdq[1], 16'h7001);
    check("inj_donecyc", dc, 2);
    check("inj_ndone", ndone - d0, 1);
    #1;
    check("inj_idle0", busy, 0);
    @(negedge clk);
    #1;
    check("inj_idle1", busy, 0);
    check("inj_noread", rq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
